// File: rtl/parking_lane_ctrl.sv
// Multi-lane parking occupancy controller: university and other pools with hour-driven capacity shift.
// Optional feature macro: PARKING_OVERFLOW_EN (university overflow into the other pool).
module parking_lane_ctrl #(
  parameter int unsigned UNI_CAP_MAX   = 500,
  parameter int unsigned OTHER_CAP_MAX = 200,
  parameter int unsigned RATE          = 50,
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned NUM_LANES     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [4:0]           hour,
  input  logic                 err_clr,
  input  logic [NUM_LANES-1:0] ent_req,
  input  logic [NUM_LANES-1:0] ent_is_uni,
  output logic [NUM_LANES-1:0] ent_grant,
  output logic [NUM_LANES-1:0] ent_deny,
  input  logic [NUM_LANES-1:0] ext_req,
  input  logic [NUM_LANES-1:0] ext_is_uni,
  output logic [NUM_LANES-1:0] ext_ack,
  output logic [NUM_LANES-1:0] ext_nak,
  output logic [CNT_W-1:0]     uni_parked_cars,
  output logic [CNT_W-1:0]     parked_cars,
  output logic [CNT_W-1:0]     uni_vacated_space,
  output logic [CNT_W-1:0]     vacated_space,
  output logic                 uni_is_vacated_space,
  output logic                 is_vacated_space,
  output logic                 uni_capacity_error,
  output logic                 capacity_error,
  output logic                 no_car_error
);

  localparam int unsigned AW = CNT_W + 6;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {PRE, DAY, SHIFT, EVE} phase_t;
  typedef enum logic {NORM, OVER} pool_st_t;

  phase_t               phase_q, phase_d;
  logic [1:0]           step_q, step_d;
  pool_st_t             uni_st_q, uni_st_d, oth_st_q, oth_st_d;
  logic [CNT_W-1:0]     uni_cnt_q, uni_cnt_d, oth_cnt_q, oth_cnt_d;
  logic [CNT_W-1:0]     uni_vac_q, uni_vac_d, oth_vac_q, oth_vac_d;
  logic [NUM_LANES-1:0] ent_grant_q, ent_grant_d, ent_deny_q, ent_deny_d;
  logic [NUM_LANES-1:0] ext_ack_q, ext_ack_d, ext_nak_q, ext_nak_d;
  logic                 no_car_q, no_car_d;

  logic [CNT_W-1:0]     uni_cap, oth_cap;
  logic [AW-1:0]        shift_amt;
  logic [CNT_W-1:0]     uni_run, oth_run;
  logic                 any_nak;

  // Phase and SHIFT step are registered from hour; capacities follow from them.
  always_comb begin
    phase_d = EVE;
    step_d  = '0;
    if (hour < 5'd8) begin
      phase_d = PRE;
    end else if (hour < 5'd13) begin
      phase_d = DAY;
    end else if (hour < 5'd16) begin
      phase_d = SHIFT;
      step_d  = 2'(hour - 5'd12);
    end
  end

  always_comb begin
    shift_amt = AW'(step_q) * AW'(RATE);
    uni_cap   = CNT_W'(UNI_CAP_MAX);
    oth_cap   = CNT_W'(OTHER_CAP_MAX);
    unique case (phase_q)
      SHIFT: begin
        uni_cap = CNT_W'(AW'(UNI_CAP_MAX) - shift_amt);
        oth_cap = CNT_W'(AW'(OTHER_CAP_MAX) + shift_amt);
      end
      EVE: begin
        uni_cap = CNT_W'(OTHER_CAP_MAX);
        oth_cap = CNT_W'(UNI_CAP_MAX);
      end
      default: ;
    endcase
  end

  // Lanes are resolved in order against running counts: all exits first, then all entries.
  always_comb begin
    uni_run     = uni_cnt_q;
    oth_run     = oth_cnt_q;
    ent_grant_d = '0;
    ent_deny_d  = '0;
    ext_ack_d   = '0;
    ext_nak_d   = '0;
    any_nak     = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (ext_req[i]) begin
        if (ext_is_uni[i] && uni_run != '0) begin
          uni_run      = uni_run - ONE;
          ext_ack_d[i] = 1'b1;
`ifdef PARKING_OVERFLOW_EN
        end else if (ext_is_uni[i] && oth_run != '0) begin
          oth_run      = oth_run - ONE;
          ext_ack_d[i] = 1'b1;
`endif
        end else if (!ext_is_uni[i] && oth_run != '0) begin
          oth_run      = oth_run - ONE;
          ext_ack_d[i] = 1'b1;
        end else begin
          ext_nak_d[i] = 1'b1;
          any_nak      = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (ent_req[i]) begin
        if (ent_is_uni[i] && uni_st_q == NORM && uni_run < uni_cap) begin
          uni_run        = uni_run + ONE;
          ent_grant_d[i] = 1'b1;
`ifdef PARKING_OVERFLOW_EN
        end else if (ent_is_uni[i] && oth_st_q == NORM && oth_run < oth_cap) begin
          oth_run        = oth_run + ONE;
          ent_grant_d[i] = 1'b1;
`endif
        end else if (!ent_is_uni[i] && oth_st_q == NORM && oth_run < oth_cap) begin
          oth_run        = oth_run + ONE;
          ent_grant_d[i] = 1'b1;
        end else begin
          ent_deny_d[i] = 1'b1;
        end
      end
    end

    uni_cnt_d = uni_run;
    oth_cnt_d = oth_run;
    no_car_d  = (no_car_q & ~err_clr) | any_nak;
    if (!enable) begin
      uni_cnt_d   = '0;
      oth_cnt_d   = '0;
      no_car_d    = 1'b0;
      ent_grant_d = '0;
      ent_deny_d  = '0;
      ext_ack_d   = '0;
      ext_nak_d   = '0;
    end
    uni_st_d  = (uni_cnt_d > uni_cap) ? OVER : NORM;
    oth_st_d  = (oth_cnt_d > oth_cap) ? OVER : NORM;
    uni_vac_d = (uni_cap > uni_cnt_d) ? (uni_cap - uni_cnt_d) : '0;
    oth_vac_d = (oth_cap > oth_cnt_d) ? (oth_cap - oth_cnt_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PRE;
      step_q      <= '0;
      uni_st_q    <= NORM;
      oth_st_q    <= NORM;
      uni_cnt_q   <= '0;
      oth_cnt_q   <= '0;
      uni_vac_q   <= CNT_W'(UNI_CAP_MAX);
      oth_vac_q   <= CNT_W'(OTHER_CAP_MAX);
      ent_grant_q <= '0;
      ent_deny_q  <= '0;
      ext_ack_q   <= '0;
      ext_nak_q   <= '0;
      no_car_q    <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      step_q      <= step_d;
      uni_st_q    <= uni_st_d;
      oth_st_q    <= oth_st_d;
      uni_cnt_q   <= uni_cnt_d;
      oth_cnt_q   <= oth_cnt_d;
      uni_vac_q   <= uni_vac_d;
      oth_vac_q   <= oth_vac_d;
      ent_grant_q <= ent_grant_d;
      ent_deny_q  <= ent_deny_d;
      ext_ack_q   <= ext_ack_d;
      ext_nak_q   <= ext_nak_d;
      no_car_q    <= no_car_d;
    end
  end

  assign ent_grant            = ent_grant_q;
  assign ent_deny             = ent_deny_q;
  assign ext_ack              = ext_ack_q;
  assign ext_nak              = ext_nak_q;
  assign uni_parked_cars      = uni_cnt_q;
  assign parked_cars          = oth_cnt_q;
  assign uni_vacated_space    = uni_vac_q;
  assign vacated_space        = oth_vac_q;
  assign uni_is_vacated_space = (uni_vac_q != '0);
  assign is_vacated_space     = (oth_vac_q != '0);
  assign uni_capacity_error   = (uni_st_q == OVER);
  assign capacity_error       = (oth_st_q == OVER);
  assign no_car_error         = no_car_q;

endmodule

// File: tb/tb_parking_lane_ctrl.sv
// Scoreboard bench for parking_lane_ctrl: a per-cycle behavioural model pushes expectations, a monitor compares.
module tb_parking_lane_ctrl;
  localparam int NL   = 2;
  localparam int CW   = 10;
  localparam int UMAX = 500;
  localparam int OMAX = 200;
  localparam int RT   = 50;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b1, err_clr = 1'b0;
  logic [4:0] hour = 5'd0;
  logic [NL-1:0] ent_req = '0, ent_is_uni = '0, ext_req = '0, ext_is_uni = '0;
  logic [NL-1:0] ent_grant, ent_deny, ext_ack, ext_nak;
  logic [CW-1:0] uni_parked_cars, parked_cars, uni_vacated_space, vacated_space;
  logic uni_is_vacated_space, is_vacated_space, uni_capacity_error, capacity_error, no_car_error;

  always #5 clk = ~clk;

  parking_lane_ctrl #(
    .UNI_CAP_MAX(UMAX), .OTHER_CAP_MAX(OMAX), .RATE(RT), .CNT_W(CW), .NUM_LANES(NL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .hour(hour), .err_clr(err_clr),
    .ent_req(ent_req), .ent_is_uni(ent_is_uni), .ent_grant(ent_grant), .ent_deny(ent_deny),
    .ext_req(ext_req), .ext_is_uni(ext_is_uni), .ext_ack(ext_ack), .ext_nak(ext_nak),
    .uni_parked_cars(uni_parked_cars), .parked_cars(parked_cars),
    .uni_vacated_space(uni_vacated_space), .vacated_space(vacated_space),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .uni_capacity_error(uni_capacity_error), .capacity_error(capacity_error),
    .no_car_error(no_car_error)
  );

  typedef struct {
    int eg, ed, xa, xn;
    int uc, oc, uv, ov;
    int ue, oe, nce;
  } exp_t;

  exp_t sb[$];
  int unsigned vecs = 0, errs = 0;

  // Reference state: counts, capacities in force this cycle, overflow flags, sticky error.
  int m_uc = 0, m_oc = 0, m_ucap = UMAX, m_ocap = OMAX;
  int m_uov = 0, m_oov = 0, m_nce = 0;

  function automatic int cap_of(input int h, input bit uni);
    if (h < 13) return uni ? UMAX : OMAX;
    if (h < 16) return uni ? (UMAX - (h - 12) * RT) : (OMAX + (h - 12) * RT);
    return uni ? OMAX : UMAX;
  endfunction

  function automatic bit chance(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input bit clr, input logic [4:0] h,
                       input logic [NL-1:0] er, input logic [NL-1:0] eu,
                       input logic [NL-1:0] xr, input logic [NL-1:0] xu);
    exp_t e;
    bit nak;
    @(negedge clk);
    reset = rst; enable = en; err_clr = clr; hour = h;
    ent_req = er; ent_is_uni = eu; ext_req = xr; ext_is_uni = xu;
    e.eg = 0; e.ed = 0; e.xa = 0; e.xn = 0;
    nak = 0;
    if (rst) begin
      m_uc = 0; m_oc = 0; m_uov = 0; m_oov = 0; m_nce = 0;
      m_ucap = UMAX; m_ocap = OMAX;
    end else if (!en) begin
      m_uc = 0; m_oc = 0; m_uov = 0; m_oov = 0; m_nce = 0;
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (xr[l]) begin
          if (xu[l] && m_uc > 0) begin m_uc--; e.xa |= (1 << l); end
`ifdef PARKING_OVERFLOW_EN
          else if (xu[l] && m_oc > 0) begin m_oc--; e.xa |= (1 << l); end
`endif
          else if (!xu[l] && m_oc > 0) begin m_oc--; e.xa |= (1 << l); end
          else begin e.xn |= (1 << l); nak = 1; end
        end
      end
      for (int l = 0; l < NL; l++) begin
        if (er[l]) begin
          if (eu[l] && !m_uov && m_uc < m_ucap) begin m_uc++; e.eg |= (1 << l); end
`ifdef PARKING_OVERFLOW_EN
          else if (eu[l] && !m_oov && m_oc < m_ocap) begin m_oc++; e.eg |= (1 << l); end
`endif
          else if (!eu[l] && !m_oov && m_oc < m_ocap) begin m_oc++; e.eg |= (1 << l); end
          else e.ed |= (1 << l);
        end
      end
      m_nce = (m_nce && !clr) || nak;
      m_uov = (m_uc > m_ucap);
      m_oov = (m_oc > m_ocap);
    end
    e.uc = m_uc; e.oc = m_oc;
    e.uv = (m_ucap > m_uc) ? m_ucap - m_uc : 0;
    e.ov = (m_ocap > m_oc) ? m_ocap - m_oc : 0;
    e.ue = m_uov; e.oe = m_oov; e.nce = m_nce;
    if (!rst) begin
      m_ucap = cap_of(int'(h), 1'b1);
      m_ocap = cap_of(int'(h), 1'b0);
    end
    sb.push_back(e);
  endtask

  task automatic seg(input int n, input int h_lo, input int h_hi, input int pent,
                     input int pext, input int puni, input int pdis, input int prst);
    logic [NL-1:0] er, eu, xr, xu;
    for (int k = 0; k < n; k++) begin
      for (int l = 0; l < NL; l++) begin
        er[l] = chance(pent); eu[l] = chance(puni);
        xr[l] = chance(pext); xu[l] = chance(puni);
      end
      cycle(chance(prst), !chance(pdis), chance(5), 5'($urandom_range(h_hi, h_lo)),
            er, eu, xr, xu);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        if ((ent_grant | ent_deny | ext_ack | ext_nak) != '0) begin
          vecs++; errs++;
          $display("FAIL unexpected_pulse: got %b/%b/%b/%b expected none at %0t",
                   ent_grant, ent_deny, ext_ack, ext_nak, $time);
        end
      end else begin
        e = sb.pop_front();
        check("ent_grant", int'(ent_grant), e.eg);
        check("ent_deny", int'(ent_deny), e.ed);
        check("ext_ack", int'(ext_ack), e.xa);
        check("ext_nak", int'(ext_nak), e.xn);
        check("uni_parked_cars", int'(uni_parked_cars), e.uc);
        check("parked_cars", int'(parked_cars), e.oc);
        check("uni_vacated_space", int'(uni_vacated_space), e.uv);
        check("vacated_space", int'(vacated_space), e.ov);
        check("uni_is_vacated_space", int'(uni_is_vacated_space), int'(e.uv != 0));
        check("is_vacated_space", int'(is_vacated_space), int'(e.ov != 0));
        check("uni_capacity_error", int'(uni_capacity_error), e.ue);
        check("capacity_error", int'(capacity_error), e.oe);
        check("no_car_error", int'(no_car_error), e.nce);
      end
    end
  end

  initial begin : driver
    int waitc;
    cycle(1, 1, 0, 5'd9, '0, '0, '0, '0);
    cycle(1, 1, 0, 5'd9, '0, '0, '0, '0);
    // Three single university entries at hour 9.
    cycle(0, 1, 0, 5'd9, '0, '0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 5'd9, 2'b01, 2'b01, '0, '0);
      cycle(0, 1, 0, 5'd9, '0, '0, '0, '0);
    end
    check("directed_uni_count", int'(uni_parked_cars), 3);
    check("directed_uni_vacated", int'(uni_vacated_space), 497);
    // Empty-pool exit of the other class naks and sets the sticky flag.
    cycle(0, 1, 0, 5'd9, '0, '0, 2'b01, 2'b00);
    cycle(0, 1, 0, 5'd9, '0, '0, '0, '0);
    cycle(0, 1, 1, 5'd9, '0, '0, '0, '0);
    // Fill, capacity shift through the afternoon, drain, then unconstrained traffic.
    seg(700, 9, 9, 90, 10, 70, 0, 0);
    seg(100, 13, 13, 50, 50, 60, 0, 0);
    seg(100, 14, 14, 50, 50, 60, 0, 0);
    seg(100, 15, 15, 50, 50, 60, 0, 0);
    seg(150, 16, 23, 40, 60, 60, 0, 0);
    seg(800, 0, 31, 10, 90, 50, 0, 0);
    seg(600, 0, 31, 50, 50, 50, 3, 1);
    seg(4, 9, 9, 0, 0, 50, 0, 0);
    waitc = 0;
    while (sb.size() != 0 && waitc < 20) begin
      @(posedge clk);
      waitc++;
    end
    #2;
    if (sb.size() != 0) begin
      vecs++; errs++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
